dec_bcd: RTL and testbench



---
 rtl/dec_bcd.sv | 75 +++++++
 tb/tb_dec_bcd.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dec_bcd.sv
// BCD-to-decimal one-hot decoder.
// Provides a zero-latency decode, a registered copy for pipelined consumers,
// and monitoring of invalid codes through a sticky flag and a saturating counter.
module dec_bcd #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           in,
  input  logic                 clr_err,
  output logic [9:0]           out,
  output logic                 valid,
  output logic [9:0]           out_q,
  output logic                 valid_q,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // The counter width must be at least one bit.
  if (ERR_CNT_W < 1) begin : gen_bad_width
    $error("dec_bcd: ERR_CNT_W must be at least 1");
  end

  logic                 errSticky_d;
  logic [ERR_CNT_W-1:0] errCnt_d;

  // Decode the digit. Codes 10..15 produce an all-zero output and drop valid.
  always_comb begin
    out   = '0;
    valid = 1'b0;
    if (in <= 4'd9) begin
      out   = 10'd1 << in;
      valid = 1'b1;
    end
  end

  // Next state of the error monitor. A clear wins over an invalid code in
  // the same cycle, and the counter sticks at all-ones instead of wrapping.
  always_comb begin
    errSticky_d = err_sticky;
    errCnt_d    = err_cnt;
    if (clr_err) begin
      errSticky_d = 1'b0;
      errCnt_d    = '0;
    end else if (!valid) begin
      errSticky_d = 1'b1;
      if (err_cnt != '1) begin
        errCnt_d = err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  // One-cycle registered copy of the decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out;
      valid_q <= valid;
    end
  end

  // Error monitor state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      err_sticky <= errSticky_d;
      err_cnt    <= errCnt_d;
    end
  end

endmodule

// File: tb/tb_dec_bcd.sv
// Self-checking bench for dec_bcd: a default-width instance and a 2-bit
// counter instance share the same stimulus and are checked against a
// behavioural model of the decoder and error monitor.
module tb_dec_bcd;

  logic       clk;
  logic       rstN;
  logic       clkEn;
  logic [3:0] inDigit;
  logic       clrErr;

  logic [9:0] outA, outQA;
  logic       validA, validQA, stickyA;
  logic [7:0] cntA;

  logic [9:0] outB, outQB;
  logic       validB, validQB, stickyB;
  logic [1:0] cntB;

  int testsRun;
  int testsFailed;

  // Model state
  int expOutQ;
  int expValidQ;
  int expSticky;
  int expCntA;
  int expCntB;

  dec_bcd #(.ERR_CNT_W(8)) dutA (
    .clk(clk), .rst_n(rstN), .in(inDigit), .clr_err(clrErr),
    .out(outA), .valid(validA), .out_q(outQA), .valid_q(validQA),
    .err_sticky(stickyA), .err_cnt(cntA)
  );

  dec_bcd #(.ERR_CNT_W(2)) dutB (
    .clk(clk), .rst_n(rstN), .in(inDigit), .clr_err(clrErr),
    .out(outB), .valid(validB), .out_q(outQB), .valid_q(validQB),
    .err_sticky(stickyB), .err_cnt(cntB)
  );

  // Gated free-running clock so the combinational sweeps can run clockless
  initial clk = 1'b0;
  always begin
    #5;
    if (clkEn) clk = ~clk;
  end

  // Expected decode: a single set bit at position v for BCD codes, else zero
  function automatic int decodeOf(input int v);
    if (v >= 0 && v <= 9) return 1 << v;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int digit, input bit clr);
    inDigit = 4'(digit);
    clrErr  = clr;
  endtask

  // Behavioural model of the registered path and the error monitor
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      expOutQ = 0; expValidQ = 0; expSticky = 0; expCntA = 0; expCntB = 0;
    end else begin
      expOutQ   = decodeOf(int'(inDigit));
      expValidQ = (inDigit <= 9) ? 1 : 0;
      if (clrErr) begin
        expSticky = 0; expCntA = 0; expCntB = 0;
      end else if (inDigit > 9) begin
        expSticky = 1;
        expCntA = (expCntA + 1 > 255) ? 255 : expCntA + 1;
        expCntB = (expCntB + 1 > 3) ? 3 : expCntB + 1;
      end
    end
  end

  task automatic checkAll();
    checkOutput("outA", int'(outA), decodeOf(int'(inDigit)));
    checkOutput("validA", int'(validA), (inDigit <= 9) ? 1 : 0);
    checkOutput("outB", int'(outB), decodeOf(int'(inDigit)));
    checkOutput("outQA", int'(outQA), expOutQ);
    checkOutput("validQA", int'(validQA), expValidQ);
    checkOutput("outQB", int'(outQB), expOutQ);
    checkOutput("validQB", int'(validQB), expValidQ);
    checkOutput("stickyA", int'(stickyA), expSticky);
    checkOutput("stickyB", int'(stickyB), expSticky);
    checkOutput("cntA", int'(cntA), expCntA);
    checkOutput("cntB", int'(cntB), expCntB);
  endtask

  // Compare process: every clock cycle, shortly after the active edge
  always @(posedge clk) begin
    #2;
    checkAll();
  end

  initial begin
    int satExp [6];
    testsRun    = 0;
    testsFailed = 0;
    clkEn   = 1'b0;
    rstN    = 1'b0;
    applyStimulus(0, 1'b0);
    #5;

    // Reset state with no clock
    checkOutput("rst_outQ", int'(outQA), 0);
    checkOutput("rst_validQ", int'(validQA), 0);
    checkOutput("rst_sticky", int'(stickyA), 0);
    checkOutput("rst_cnt", int'(cntA), 0);

    // Clockless combinational sweep of all 16 codes
    for (int v = 0; v < 16; v++) begin
      inDigit = 4'(v);
      #5;
      checkOutput("sweep_out", int'(outA), decodeOf(v));
      checkOutput("sweep_valid", int'(validA), (v <= 9) ? 1 : 0);
      if (v == 3) checkOutput("lit_out3", int'(outA), 'b00_0000_1000);
      if (v == 8) checkOutput("lit_out8", int'(outA), 'b01_0000_0000);
      if (v == 12) checkOutput("lit_out12", int'(outA), 0);
    end

    applyStimulus(0, 1'b0);
    #5;
    rstN  = 1'b1;
    #3;
    clkEn = 1'b1;

    // Registered path latency
    @(negedge clk); applyStimulus(5, 1'b0);
    @(negedge clk);
    checkOutput("lit_outQ5", int'(outQA), 'b00_0010_0000);
    checkOutput("lit_validQ5", int'(validQA), 1);
    applyStimulus(7, 1'b0);
    @(negedge clk);
    checkOutput("lit_outQ7", int'(outQA), 'b00_1000_0000);
    checkOutput("lit_validQ7", int'(validQA), 1);

    // Invalid code for three edges, then hold with a valid code, then clear
    applyStimulus(12, 1'b0);
    @(negedge clk);
    checkOutput("lit_sticky1", int'(stickyA), 1);
    checkOutput("lit_cnt1", int'(cntA), 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("lit_cnt3", int'(cntA), 3);
    applyStimulus(2, 1'b0);
    @(negedge clk);
    checkOutput("lit_cntHold", int'(cntA), 3);
    checkOutput("lit_stickyHold", int'(stickyA), 1);
    applyStimulus(2, 1'b1);
    @(negedge clk);
    checkOutput("lit_cntClr", int'(cntA), 0);
    checkOutput("lit_stickyClr", int'(stickyA), 0);

    // Saturation of the 2-bit counter
    satExp = '{1, 2, 3, 3, 3, 3};
    applyStimulus(15, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("lit_satB", int'(cntB), satExp[i]);
    end
    checkOutput("lit_cntA6", int'(cntA), 6);

    // Mid-cycle asynchronous reset while registered state is nonzero
    applyStimulus(4, 1'b0);
    @(negedge clk);
    #1 rstN = 1'b0;
    #1;
    checkOutput("arst_outQ", int'(outQA), 0);
    checkOutput("arst_validQ", int'(validQA), 0);
    checkOutput("arst_sticky", int'(stickyA), 0);
    checkOutput("arst_cntA", int'(cntA), 0);
    checkOutput("arst_cntB", int'(cntB), 0);
    checkOutput("arst_out", int'(outA), 'b00_0001_0000);
    rstN = 1'b1;

    // Randomised phase with occasional clears and mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      applyStimulus(int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 63) == 0) begin
        #1 rstN = 1'b0;
        #1;
        checkOutput("rnd_arst_cntA", int'(cntA), 0);
        checkOutput("rnd_arst_outQ", int'(outQA), 0);
        rstN = 1'b1;
      end
    end

    @(negedge clk);
    clkEn = 1'b0;
    #20;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
